// File: rtl/tlc_pkg.sv
// Shared types and lamp constants for the traffic light phase sequencer.
package tlc_pkg;

  typedef enum logic [2:0] {
    ALL_RED,
    MAIN_GRN,
    MAIN_YEL,
    SIDE_GRN,
    SIDE_YEL,
    WALK
  } tlc_state_e;

  typedef enum logic [1:0] {
    LOAD,
    FIRE,
    WAIT
  } tlc_phase_e;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  // A zero interval would never give the timer a fresh expiry edge.
  function automatic logic interval_ok(int unsigned v);
    return (v >= 1) && (v <= 15);
  endfunction

endpackage

// File: rtl/tlc_phase_fsm_timer_if.sv
// Timer handshake: expiry synchroniser/edge detect, LOAD/FIRE/WAIT phase
// counter and start pulse. arm + value in, one-cycle done out.
module tlc_timer_if
  import tlc_pkg::*;
#(
  parameter logic [3:0] RESET_VALUE = 4'd2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       expired,
  input  logic       arm,
  input  logic [3:0] value,
  output logic       done,
  output logic [3:0] interval_value,
  output logic       start_timer
);

  tlc_phase_e phase_q, phase_d;
  logic       exp_s1_q, exp_s2_q, exp_prev_q;
  logic       boot_q;
  logic       done_q, done_d;
  logic       start_q, start_d;
  logic [3:0] value_q, value_d;
  logic       exp_rise;

  assign exp_rise = exp_s2_q & ~exp_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= LOAD;
      exp_s1_q   <= 1'b0;
      exp_s2_q   <= 1'b0;
      exp_prev_q <= 1'b0;
      boot_q     <= 1'b1;
      done_q     <= 1'b0;
      start_q    <= 1'b0;
      value_q    <= RESET_VALUE;
    end else begin
      phase_q    <= phase_d;
      exp_s1_q   <= expired;
      exp_s2_q   <= exp_s1_q;
      exp_prev_q <= exp_s2_q;
      boot_q     <= 1'b0;
      done_q     <= done_d;
      start_q    <= start_d;
      value_q    <= value_d;
    end
  end

  // The first edge after reset release stands in for the load edge, so the
  // reset interval is held a full cycle before the start pulse.
  always_comb begin
    phase_d = phase_q;
    value_d = value_q;
    start_d = 1'b0;
    done_d  = 1'b0;
    if (arm) begin
      phase_d = LOAD;
      value_d = value;
    end else begin
      unique case (phase_q)
        LOAD: begin
          if (!boot_q) begin
            phase_d = FIRE;
            start_d = 1'b1;
          end
        end
        FIRE:    phase_d = WAIT;
        WAIT:    done_d  = exp_rise;
        default: phase_d = LOAD;
      endcase
    end
  end

  assign done           = done_q;
  assign interval_value = value_q;
  assign start_timer    = start_q;

endmodule

// File: rtl/tlc_phase_fsm.sv
// Traffic light phase sequencer: state FSM, request latches, lamp decode.
// Optional pedestrian walk phase enabled by `define TLC_PED_WALK_EN.
module tlc_phase_fsm
  import tlc_pkg::*;
#(
  parameter int unsigned T_ALLRED   = 2,
  parameter int unsigned T_MAIN_GRN = 8,
  parameter int unsigned T_SIDE_GRN = 5,
  parameter int unsigned T_YEL      = 2,
  parameter int unsigned T_WALK     = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sensor,
  input  logic       expired,
  output logic [3:0] interval_value,
  output logic       start_timer,
  output logic [2:0] main_lights,
  output logic [2:0] side_lights
`ifdef TLC_PED_WALK_EN
  ,
  input  logic       walk_req,
  output logic       walk
`endif
);

  if (!(interval_ok(T_ALLRED) && interval_ok(T_MAIN_GRN) && interval_ok(T_SIDE_GRN) &&
        interval_ok(T_YEL) && interval_ok(T_WALK))) begin : g_bad_interval
    $error("tlc_phase_fsm: every interval parameter must lie in 1..15");
  end

  function automatic logic [3:0] interval_of(tlc_state_e s);
    logic [3:0] v;
    unique case (s)
      MAIN_GRN:           v = 4'(T_MAIN_GRN);
      SIDE_GRN:           v = 4'(T_SIDE_GRN);
      MAIN_YEL, SIDE_YEL: v = 4'(T_YEL);
      WALK:               v = 4'(T_WALK);
      default:            v = 4'(T_ALLRED);
    endcase
    return v;
  endfunction

  tlc_state_e state_q, state_d;
  logic       sens_s1_q, sens_s2_q;
  logic       car_q, car_d;
  logic [2:0] main_q, main_d, side_q, side_d;
  logic       done;
  logic [3:0] next_value;
  logic       walk_pend;
`ifdef TLC_PED_WALK_EN
  logic       walk_s1_q, walk_s2_q;
  logic       walk_pend_q, walk_pend_d;
  logic       walk_q, walk_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ALL_RED;
      sens_s1_q   <= 1'b0;
      sens_s2_q   <= 1'b0;
      car_q       <= 1'b0;
      main_q      <= LAMP_R;
      side_q      <= LAMP_R;
`ifdef TLC_PED_WALK_EN
      walk_s1_q   <= 1'b0;
      walk_s2_q   <= 1'b0;
      walk_pend_q <= 1'b0;
      walk_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sens_s1_q   <= sensor;
      sens_s2_q   <= sens_s1_q;
      car_q       <= car_d;
      main_q      <= main_d;
      side_q      <= side_d;
`ifdef TLC_PED_WALK_EN
      walk_s1_q   <= walk_req;
      walk_s2_q   <= walk_s1_q;
      walk_pend_q <= walk_pend_d;
      walk_q      <= walk_d;
`endif
    end
  end

  // Clearing on entry takes priority over a request seen on the same edge.
  always_comb begin
`ifdef TLC_PED_WALK_EN
    walk_pend = walk_pend_q;
`else
    walk_pend = 1'b0;
`endif
    state_d = state_q;
    if (done) begin
      unique case (state_q)
        ALL_RED:  state_d = MAIN_GRN;
        MAIN_GRN: state_d = (car_q || walk_pend) ? MAIN_YEL : MAIN_GRN;
        MAIN_YEL: state_d = SIDE_GRN;
        SIDE_GRN: state_d = SIDE_YEL;
        SIDE_YEL: state_d = walk_pend ? WALK : ALL_RED;
        default:  state_d = ALL_RED;
      endcase
    end
    car_d = (done && (state_d == SIDE_GRN)) ? 1'b0 : (car_q | sens_s2_q);
`ifdef TLC_PED_WALK_EN
    walk_pend_d = (done && (state_d == WALK)) ? 1'b0 : (walk_pend_q | walk_s2_q);
`endif
  end

  always_comb begin
    main_d     = LAMP_R;
    side_d     = LAMP_R;
    next_value = interval_of(state_d);
    unique case (state_d)
      MAIN_GRN: main_d = LAMP_G;
      MAIN_YEL: main_d = LAMP_Y;
      SIDE_GRN: side_d = LAMP_G;
      SIDE_YEL: side_d = LAMP_Y;
      default: begin
        main_d = LAMP_R;
        side_d = LAMP_R;
      end
    endcase
`ifdef TLC_PED_WALK_EN
    walk_d = (state_d == WALK);
`endif
  end

  tlc_timer_if #(
    .RESET_VALUE (4'(T_ALLRED))
  ) u_timer_if (
    .clk            (clk),
    .rst_n          (rst_n),
    .expired        (expired),
    .arm            (done),
    .value          (next_value),
    .done           (done),
    .interval_value (interval_value),
    .start_timer    (start_timer)
  );

  assign main_lights = main_q;
  assign side_lights = side_q;
`ifdef TLC_PED_WALK_EN
  assign walk        = walk_q;
`endif

endmodule
